scanline_feeder: RTL
====================

# scanline_feeder

Producer-side line streamer for the VGA pixel pipeline. It double-buffers one 256-pixel NES scanline of 6-bit colour codes written by the PPU and serves that line to the VGA block's `c_dat` input, one code per cycle while the VGA block asserts `reading`. Each fully written line is swapped to the front only between VGA read bursts. Underruns replay the previous line and are flagged.

## Interface
- `LINE_PIXELS`, 256: pixels per NES scanline and the read/write address range.
- `LINES`, 240: NES scanlines per frame, used by the line counter.
- `CW`, 6: colour code width.

Ports:
- `clk` in 1: pixel clock, the same clock as the VGA block.
- `reset` in 1: asynchronous, active-high.
- `wr_en` in 1: write strobe into the back buffer.
- `wr_x` in 8: pixel index for the write.
- `wr_dat` in CW: colour code to write.
- `wr_line_done` in 1: single-cycle pulse; the back buffer line is complete.
- `wr_ready` out 1: the back buffer accepts writes (`!back_full`).
- `reading` in 1: VGA stream read request, high for 256 consecutive cycles per streamed line.
- `c_dat` out CW: colour code for the current read cycle. It is combinational from the front buffer.
- `line_idx` out 8: index of the NES line being streamed or streamed next, 0..239.
- `frame_done` out 1: single-cycle pulse after line 239 finishes streaming.
- `underrun` out 1: sticky flag; a line burst started without a fresh line.
- `underrun_clr` in 1: synchronous clear of `underrun`.

## Operation
- Storage: two LINE_PIXELS×CW arrays, `buf0` and `buf1`. `front_sel` selects the front array; the other array is the back buffer.
- Array contents are not reset. The `front_valid` flag gates `c_dat` to 0 until the first swap.
- Write path: when `wr_en && !back_full`, set `back[wr_x] <= wr_dat`. When `back_full=1`, `wr_en` is ignored.
- Line completion: `wr_line_done && !back_full` sets `back_full`. When `back_full=1`, the pulse is ignored.
- `wr_en` and `wr_line_done` may arrive in the same cycle. The write lands, then the buffer is marked full.
- Read path: `c_dat = front_valid ? front[rd_ptr] : 0`.
- `rd_ptr` increments on every cycle with `reading=1`. It clears to 0 on the cycle after `reading` falls.
- If `reading` stays high for more than 256 cycles, `rd_ptr` wraps from 255 to 0 and nothing else changes.
- Swap: in any cycle with `reading=0 && back_full=1`, the block toggles `front_sel`, clears `back_full`, and sets `fresh=1` and `front_valid=1`.
- A swap never occurs while `reading=1`, so the front buffer is stable for the whole burst.
- Burst start: the rising edge of `reading` is detected against the registered `reading_d`.
  - If `fresh=0` at that point, set `underrun=1`. The front line is replayed unchanged.
  - In either case, `fresh` clears on the falling edge of `reading`.
- Line counter: on the falling edge of `reading`, `line_idx` increments. At 239 it wraps to 0, and `frame_done` pulses for 1 cycle.
- Clear priority: `underrun_clr` and a new underrun in the same cycle leave `underrun=1` (set wins).

## Timing
- Reset values:
  - `front_sel=0`, `back_full=0`, `wr_ready=1`, `fresh=0`, `front_valid=0`.
  - `rd_ptr=0`, `line_idx=0`, `frame_done=0`, `underrun=0`, `c_dat=0`.
- Read latency is zero: `c_dat` reflects `rd_ptr` in the same cycle. The first burst cycle presents `front[0]`, and the Nth `reading` cycle presents `front[N-1]`.
- `wr_line_done` at cycle t sets `back_full` at t+1, and `wr_ready` drops at t+1.
  - If `reading=0` at t+1, the swap takes effect at t+2. At t+2 `wr_ready=1` again.
  - If `reading=1`, the swap happens in the first `reading=0` cycle after the burst ends.
- Falling-edge actions (`rd_ptr` clear, `line_idx` increment, `fresh` clear, `frame_done` pulse) are all registered on the first cycle with `reading=0 && reading_d=1`.
- A swap may occur in that same cycle, and its `fresh=1` set wins over the clear.
- Reset asserted mid-burst: all state returns to reset values immediately and `c_dat` goes to 0. The next `reading` rise counts as an underrun if no line was written.

## Test plan
- Basic stream: write `c = x & 6'h3F` for x = 0..255, pulse `wr_line_done`, wait 2 cycles, hold `reading` for 256 cycles -> `c_dat` equals 0,1,…,63,0,… in order; `underrun` stays 0; `line_idx` goes 0->1.
- Double buffer: during burst 1, write back buffer with all 6'h2A and pulse `wr_line_done` at burst cycle 100 -> burst 1 `c_dat` is unchanged; swap occurs on the first `reading`-low cycle; burst 2 `c_dat` is 6'h2A throughout.
- Underrun: after one good line, start a second burst with no `wr_line_done` -> `underrun=1` at the rise+1 cycle; burst 2 `c_dat` replays line 1 exactly; `underrun_clr` clears it to 0.
- Back-pressure: with `back_full=1` and `reading=1`, issue `wr_en` with `wr_x=5`, `wr_dat=6'h11` -> write is dropped; `wr_ready=0` until the swap; after the swap, `back[5]` is unchanged.
- Frame wrap: stream 240 bursts, each with a fresh line -> `frame_done` pulses exactly once, on the falling edge of burst 240; `line_idx` returns to 0.
- Reset mid-burst: assert `reset` at burst cycle 50 -> `c_dat=0`, `wr_ready=1`, `line_idx=0` immediately; after release, a burst without a written line sets `underrun=1` and outputs all zeros.

Source files
------------

// File: rtl/scanline_feeder_if.sv
// scanline_feeder_if: groups the PPU write port, the VGA read port and the
// status outputs of scanline_feeder into one bundle.
//   master : drives wr_en/wr_x/wr_dat/wr_line_done, reading, underrun_clr
//   slave  : drives wr_ready, c_dat, line_idx, frame_done, underrun
interface scanline_feeder_if #(
   parameter int CW = 6
);
   logic          wr_en;
   logic [7:0]    wr_x;
   logic [CW-1:0] wr_dat;
   logic          wr_line_done;
   logic          wr_ready;
   logic          reading;
   logic [CW-1:0] c_dat;
   logic [7:0]    line_idx;
   logic          frame_done;
   logic          underrun;
   logic          underrun_clr;

   modport master (
      output wr_en, wr_x, wr_dat, wr_line_done, reading, underrun_clr,
      input  wr_ready, c_dat, line_idx, frame_done, underrun
   );

   modport slave (
      input  wr_en, wr_x, wr_dat, wr_line_done, reading, underrun_clr,
      output wr_ready, c_dat, line_idx, frame_done, underrun
   );
endinterface

// File: rtl/scanline_feeder.sv
// scanline_feeder: double-buffered NES scanline streamer for the VGA block.
// The PPU fills the back buffer and marks it complete; the line is swapped
// to the front only while the VGA block is not reading, then streamed one
// colour code per cycle while `reading` is high.
// Ports:
//   clk   : pixel clock (shared with the VGA block)
//   reset : asynchronous, active-high
//   bus   : scanline_feeder_if.slave -- write port, read port, status
module scanline_feeder #(
   parameter int LINE_PIXELS = 256,
   parameter int LINES       = 240,
   parameter int CW          = 6
) (
   input  logic              clk,
   input  logic              reset,
   scanline_feeder_if.slave  bus
);
   localparam logic [7:0] LAST_PIX  = 8'(LINE_PIXELS - 1);
   localparam logic [7:0] LAST_LINE = 8'(LINES - 1);

   // Line storage; contents are deliberately not reset.
   logic [CW-1:0] buf0 [LINE_PIXELS];
   logic [CW-1:0] buf1 [LINE_PIXELS];

   logic       front_sel_q,    front_sel_d;
   logic       back_full_q,    back_full_d;
   logic       fresh_q,        fresh_d;
   logic       front_valid_q,  front_valid_d;
   logic       reading_prev_q;
   logic [7:0] rd_ptr_q,       rd_ptr_d;
   logic [7:0] line_idx_q,     line_idx_d;
   logic       frame_done_q,   frame_done_d;
   logic       underrun_q,     underrun_d;

   logic          rise, fall, swap, wr_ok;
   logic [CW-1:0] front_pix;

   always_comb begin
      rise  = bus.reading && !reading_prev_q;
      fall  = !bus.reading && reading_prev_q;
      swap  = !bus.reading && back_full_q;
      wr_ok = bus.wr_en && !back_full_q;

      front_sel_d   = front_sel_q;
      back_full_d   = back_full_q;
      fresh_d       = fresh_q;
      front_valid_d = front_valid_q;
      rd_ptr_d      = '0;
      line_idx_d    = line_idx_q;
      frame_done_d  = 1'b0;
      underrun_d    = underrun_q;

      if (bus.reading) begin
         rd_ptr_d = (rd_ptr_q == LAST_PIX) ? '0 : rd_ptr_q + 8'd1;
      end

      if (fall) begin
         fresh_d      = 1'b0;
         line_idx_d   = (line_idx_q == LAST_LINE) ? '0 : line_idx_q + 8'd1;
         frame_done_d = (line_idx_q == LAST_LINE);
      end

      // A swap on the falling-edge cycle must leave fresh set, so it is
      // evaluated after the falling-edge clear.
      if (swap) begin
         front_sel_d   = !front_sel_q;
         back_full_d   = 1'b0;
         fresh_d       = 1'b1;
         front_valid_d = 1'b1;
      end else if (bus.wr_line_done && !back_full_q) begin
         back_full_d = 1'b1;
      end

      // Set beats clear.
      if (rise && !fresh_q) begin
         underrun_d = 1'b1;
      end else if (bus.underrun_clr) begin
         underrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         front_sel_q    <= 1'b0;
         back_full_q    <= 1'b0;
         fresh_q        <= 1'b0;
         front_valid_q  <= 1'b0;
         reading_prev_q <= 1'b0;
         rd_ptr_q       <= '0;
         line_idx_q     <= '0;
         frame_done_q   <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         front_sel_q    <= front_sel_d;
         back_full_q    <= back_full_d;
         fresh_q        <= fresh_d;
         front_valid_q  <= front_valid_d;
         reading_prev_q <= bus.reading;
         rd_ptr_q       <= rd_ptr_d;
         line_idx_q     <= line_idx_d;
         frame_done_q   <= frame_done_d;
         underrun_q     <= underrun_d;
      end
   end

   // The back buffer is whichever array is not selected as front.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         if (front_sel_q) begin
            buf0[bus.wr_x] <= bus.wr_dat;
         end else begin
            buf1[bus.wr_x] <= bus.wr_dat;
         end
      end
   end

   always_comb begin
      front_pix = front_sel_q ? buf1[rd_ptr_q] : buf0[rd_ptr_q];
   end

   assign bus.c_dat      = front_valid_q ? front_pix : '0;
   assign bus.wr_ready   = !back_full_q;
   assign bus.line_idx   = line_idx_q;
   assign bus.frame_done = frame_done_q;
   assign bus.underrun   = underrun_q;
endmodule
